// File: rtl/retospect_cfg_loader.sv
// -----------------------------------------------------------------------------
// retospect_cfg_loader
//
// Streams host bytes (LSB first) into a serial configuration shift chain of
// CHAIN_LEN bits, optionally reads the chain back by rotating it once while
// comparing rotate-xor signatures, then pulses the chain's network-state reset
// and reports completion.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, verify_en    load request (IDLE only); verify_en sampled with start
//   byte_valid/ready    host byte handshake, byte_data is the byte
//   cfg_en, bs_in       chain shift enable and chain input bit
//   bs_out              chain output bit
//   reset_nn            one-cycle network-state reset pulse to the chain
//   busy, done          activity flag and one-cycle completion pulse
//   underrun, mismatch  sticky status: host starved the chain / readback bad
// -----------------------------------------------------------------------------
module retospect_cfg_loader #(
   parameter int CHAIN_LEN = 523,
   parameter int CNT_W     = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       verify_en,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic       cfg_en,
   output logic       bs_in,
   input  logic       bs_out,
   output logic       reset_nn,
   output logic       busy,
   output logic       done,
   output logic       underrun,
   output logic       mismatch
);

   localparam int               NUM_BYTES   = (CHAIN_LEN + 7) / 8;
   localparam int               LAST_REM    = CHAIN_LEN % 8;
   localparam logic [3:0]       LAST_BITS   = (LAST_REM == 0) ? 4'd8 : 4'(LAST_REM);
   localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] NUM_BYTES_C = CNT_W'(NUM_BYTES);
   localparam logic [CNT_W-1:0] LAST_IDX_C  = CNT_W'(NUM_BYTES - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VERIFY, S_PULSE, S_DONE} state_t;

   state_t           state;
   logic [7:0]       sr;           // shift register feeding bs_in
   logic [3:0]       sr_cnt;       // bits still to shift out of sr
   logic [7:0]       hr;           // holding register (next byte)
   logic [3:0]       hr_cnt;       // 0 means hr is empty
   logic [CNT_W-1:0] bytes_taken;
   logic [CNT_W-1:0] bits_left;    // shifts remaining in LOAD, then in VERIFY
   logic [7:0]       sig_load;
   logic [7:0]       sig_rd;
   logic             verify_flag;

   logic             in_load;
   logic             in_verify;
   logic             shift;
   logic             accept;
   logic [3:0]       byte_bits;
   logic [3:0]       sr_cnt_after;
   logic [7:0]       sig_load_nxt;
   logic [7:0]       sig_rd_nxt;

   // NOTE: every signal is assigned unconditionally at the top of the block, so no latch can be inferred.
   always_comb begin
      in_load      = (state == S_LOAD);
      in_verify    = (state == S_VERIFY);
      byte_ready   = in_load && (hr_cnt == 4'd0) && (bytes_taken != NUM_BYTES_C);
      shift        = in_load && (sr_cnt != 4'd0);
      cfg_en       = shift || in_verify;
      // VERIFY rotates the chain: whatever falls out is fed straight back in.
      bs_in        = in_load ? sr[0] : (in_verify ? bs_out : 1'b0);
      accept       = byte_valid && byte_ready;
      // The final byte only carries the leftover chain bits; its upper bits are never shifted.
      byte_bits    = (bytes_taken == LAST_IDX_C) ? LAST_BITS : 4'd8;
      sr_cnt_after = sr_cnt - {3'b000, shift};
      sig_load_nxt = {sig_load[6:0], sig_load[7]} ^ {7'b0, bs_in};
      sig_rd_nxt   = {sig_rd[6:0], sig_rd[7]} ^ {7'b0, bs_out};
   end

   // NOTE: sequential state uses non-blocking assignments only; a later assignment in this block overrides an earlier one for the same register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         sr          <= 8'h00;
         sr_cnt      <= 4'd0;
         hr          <= 8'h00;
         hr_cnt      <= 4'd0;
         bytes_taken <= '0;
         bits_left   <= '0;
         sig_load    <= 8'h00;
         sig_rd      <= 8'h00;
         verify_flag <= 1'b0;
         underrun    <= 1'b0;
         mismatch    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         reset_nn    <= 1'b0;
      end else begin
         done     <= 1'b0;
         reset_nn <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_LOAD;
                  busy        <= 1'b1;
                  bits_left   <= CHAIN_LEN_C;
                  sig_load    <= 8'h00;
                  sig_rd      <= 8'h00;
                  underrun    <= 1'b0;
                  mismatch    <= 1'b0;
                  verify_flag <= verify_en;
                  sr_cnt      <= 4'd0;
                  hr_cnt      <= 4'd0;
                  bytes_taken <= '0;
               end
            end

            S_LOAD: begin
               if (shift) begin
                  sr        <= {1'b0, sr[7:1]};
                  sig_load  <= sig_load_nxt;
                  bits_left <= bits_left - CNT_W'(1);
               end
               sr_cnt <= sr_cnt_after;
               // The chain is starving once streaming has begun and sr has run dry.
               if ((sr_cnt == 4'd0) && (bytes_taken != '0))
                  underrun <= 1'b1;
               if (sr_cnt_after == 4'd0) begin
                  // sr empties this cycle: refill from hr, or take the incoming byte directly.
                  if (hr_cnt != 4'd0) begin
                     sr     <= hr;
                     sr_cnt <= hr_cnt;
                     hr_cnt <= 4'd0;
                  end else if (accept) begin
                     sr     <= byte_data;
                     sr_cnt <= byte_bits;
                  end
               end else if (accept) begin
                  hr     <= byte_data;
                  hr_cnt <= byte_bits;
               end
               if (accept)
                  bytes_taken <= bytes_taken + CNT_W'(1);
               if (shift && (bits_left == CNT_W'(1))) begin
                  bits_left <= CHAIN_LEN_C;
                  if (verify_flag) begin
                     state <= S_VERIFY;
                  end else begin
                     state    <= S_PULSE;
                     reset_nn <= 1'b1;
                  end
               end
            end

            S_VERIFY: begin
               sig_rd    <= sig_rd_nxt;
               bits_left <= bits_left - CNT_W'(1);
               if (bits_left == CNT_W'(1)) begin
                  mismatch <= (sig_rd_nxt != sig_load);
                  state    <= S_PULSE;
                  reset_nn <= 1'b1;
               end
            end

            S_PULSE: begin
               state <= S_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/retospect_cfg_loader.md
RETOSPECT_CFG_LOADER -- requirements
Module: retospect_cfg_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 523, meaning total bits in the configuration shift chain (clockbox 48 + 25 cells x 19).
REQ-002 Parameter CNT_W, default 10, meaning width of the bit counter; it SHALL satisfy 2^CNT_W > CHAIN_LEN.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  single-cycle request to begin a load; honoured only in IDLE.
REQ-006 verify_en  input  1  sampled with start; 1 selects a readback pass after the load.
REQ-007 byte_valid  input  1  host byte available.
REQ-008 byte_data  input  8  host byte, LSB shifted first.
REQ-009 byte_ready  output  1  loader can accept a byte this cycle.
REQ-010 cfg_en  output  1  drives chain config_en; the chain shifts one bit per clk with cfg_en=1.
REQ-011 bs_in  output  1  drives chain input bit.
REQ-012 bs_out  input  1  chain output bit.
REQ-013 reset_nn  output  1  network-state reset pulse to the chain.
REQ-014 busy  output  1  high in LOAD, VERIFY and PULSE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 underrun  output  1  sticky: the host starved the chain during LOAD.
REQ-017 mismatch  output  1  sticky: readback signature differed from load signature.

Function
REQ-018 FSM states: IDLE, LOAD, VERIFY, PULSE, DONE; the only legal transitions are those in REQ-019..REQ-025.
REQ-019 IDLE: start=1 -> LOAD next cycle; bits_left := CHAIN_LEN, sig_load := 0, sig_rd := 0, underrun := 0, mismatch := 0, verify flag := verify_en.
REQ-020 LOAD datapath: 8-bit shift register (SR) with 4-bit count plus one 8-bit holding register (HR); byte_ready = HR empty.
REQ-021 A byte is accepted on byte_valid & byte_ready; it goes to SR if SR is empty, otherwise to HR; when SR empties, HR moves to SR in the same cycle.
REQ-022 LOAD outputs are combinational: cfg_en = (SR count != 0); bs_in = SR[0]. Each cfg_en cycle shifts SR right, decrements its count and decrements bits_left.
REQ-023 Last byte: only CHAIN_LEN mod 8 low bits are shifted (8 if the remainder is 0); the remaining upper bits are discarded. No byte is accepted once ceil(CHAIN_LEN/8) bytes are taken; byte_ready=0 thereafter.
REQ-024 Signature per shifted bit b: sig := {sig[6:0], sig[7]} ^ {7'b0, b}; sig_load uses bs_in during LOAD; sig_rd uses bs_out during VERIFY.
REQ-025 Exit and sequencing:
- LOAD exits when bits_left reaches 0: to VERIFY if the verify flag is set, else to PULSE.
- VERIFY: cfg_en=1 and bs_in=bs_out (combinational rotate) for exactly CHAIN_LEN cycles, then mismatch := (sig_rd != sig_load) and go to PULSE.
- PULSE: reset_nn=1 for exactly one cycle, then DONE.
- DONE: done=1 for one cycle, then IDLE.
REQ-026 Underrun: in LOAD with bits_left>0 and SR empty, cfg_en=0 and underrun := 1; loading resumes when a byte arrives.
REQ-027 start while not IDLE SHALL be ignored. byte_valid outside LOAD SHALL be ignored, with byte_ready=0.
REQ-028 Outside LOAD/VERIFY: cfg_en=0, bs_in=0. reset_nn=0 outside PULSE.
REQ-029 Latency: start -> first cfg_en no earlier than 1 cycle after the first byte is accepted. With continuous byte_valid, LOAD lasts CHAIN_LEN cycles plus the initial acceptance cycle, with no underrun.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE and clear SR, HR, counts, bits_left, both signatures, the verify flag, underrun and mismatch.
REQ-031 During rst_n=0: byte_ready, cfg_en, bs_in, reset_nn, busy and done SHALL all be 0, including when rst_n asserts mid-LOAD or mid-VERIFY.
REQ-032 First start after rst_n deasserts behaves as REQ-019.

Verification (CHAIN_LEN=12 with a behavioural 12-bit chain model, unless stated)
REQ-033 Streaming load:
- Stimulus: start, verify_en=0, bytes 0xA5 then 0x0F back-to-back.
- Required: chain = {0xF,0xA5} with first bit deepest; exactly 12 cfg_en cycles; reset_nn one cycle, then done; underrun=0.
REQ-034 Verify pass:
- Stimulus: as REQ-033 with verify_en=1.
- Required: 12 extra cfg_en cycles; chain contents unchanged; mismatch=0.
REQ-035 Corrupted readback:
- Stimulus: verify_en=1; model flips one chain bit during VERIFY.
- Required: mismatch=1 at done.
REQ-036 Host stall:
- Stimulus: second byte delayed 5 cycles.
- Required: cfg_en low for those cycles; underrun=1; final chain still correct.
REQ-037 Abort and ignore:
- Stimulus: rst_n low mid-LOAD, then a new start; separately, start during VERIFY.
- Required: outputs zero immediately on reset and the new load completes normally; start during VERIFY has no effect.
REQ-038 Default parameter:
- Stimulus: CHAIN_LEN=523, 66 bytes.
- Required: exactly 523 shifts; bits [7:3] of the last byte are discarded.
